// File: rtl/alu_operand_buf.sv
// Registered N:1 ALU operand selector with a two-entry skid buffer.
// Optional sticky out-of-range select flag: define ALU_OPBUF_SELCHK_EN.
module alu_operand_buf #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NSRC*WIDTH-1:0] d,
    input  logic [SELW-1:0]       sel,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      y,
    output logic [SELW-1:0]       y_sel,
    output logic                  err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  head_q;
    logic [SELW-1:0]   head_sel_q;
    logic [WIDTH-1:0]  tail_q;
    logic [SELW-1:0]   tail_sel_q;
    logic [WIDTH-1:0]  wdata_d;

    // Unmatched (out-of-range) selects fall through to zero.
    always_comb begin
        wdata_d = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SELW'(k)) begin
                wdata_d = d[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            head_sel_q <= '0;
            tail_q     <= '0;
            tail_sel_q <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        head_q     <= wdata_d;
                        head_sel_q <= sel;
                        state_q    <= ONE;
                    end
                end
                ONE: begin
                    if (in_valid && !out_ready) begin
                        tail_q     <= wdata_d;
                        tail_sel_q <= sel;
                        state_q    <= FULL;
                    end else if (in_valid && out_ready) begin
                        head_q     <= wdata_d;
                        head_sel_q <= sel;
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        head_q     <= tail_q;
                        head_sel_q <= tail_sel_q;
                        state_q    <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign y         = head_q;
    assign y_sel     = head_sel_q;

`ifdef ALU_OPBUF_SELCHK_EN
    logic err_q;
    logic sel_oor;

    assign sel_oor = (int'(sel) >= NSRC);

    // Sticky until reset; a flushed input was never accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (in_valid && in_ready && !flush && sel_oor) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_operand_buf.sv
// Bench for alu_operand_buf: queue model per instance plus directed checks.
// Instances: NSRC=4 (main) and NSRC=3 (out-of-range select).
module tb_alu_operand_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic         in_valid = 0, flush = 0, out_ready = 0;
    logic [1:0]   sel = 0;
    logic [127:0] d4 = {32'd40, 32'd30, 32'd20, 32'd10};
    logic         in_ready, out_valid, err;
    logic [31:0]  y;
    logic [1:0]   y_sel;

    logic         v3 = 0, f3 = 0, or3 = 0;
    logic [1:0]   s3 = 0;
    logic [95:0]  d3 = {32'd30, 32'd20, 32'd10};
    logic         in_ready3, out_valid3, err3;
    logic [31:0]  y3;
    logic [1:0]   y_sel3;

    alu_operand_buf #(.WIDTH(32), .NSRC(4), .SELW(2)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .d(d4), .sel(sel), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .y_sel(y_sel), .err(err)
    );

    alu_operand_buf #(.WIDTH(32), .NSRC(3), .SELW(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(in_ready3),
        .d(d3), .sel(s3), .flush(f3), .out_valid(out_valid3),
        .out_ready(or3), .y(y3), .y_sel(y_sel3), .err(err3)
    );

`ifdef ALU_OPBUF_SELCHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural models: FIFO of depth 2, flush/reset empty it.
    logic [31:0] q4d[$], q3d[$];
    logic [1:0]  q4s[$], q3s[$];
    logic [31:0] y4m = 0, y3m = 0;
    logic [1:0]  ys4m = 0, ys3m = 0;
    logic        e3m = 0;

    always @(posedge clk) begin
        logic acc;
        if (rst) begin
            q4d.delete(); q4s.delete(); y4m = 0; ys4m = 0;
        end else if (flush) begin
            q4d.delete(); q4s.delete();
        end else begin
            acc = in_valid && (q4d.size() < 2);
            if (q4d.size() > 0 && out_ready) begin
                void'(q4d.pop_front()); void'(q4s.pop_front());
            end
            if (acc) begin
                q4d.push_back(32'(d4 >> (32 * int'(sel))));
                q4s.push_back(sel);
            end
        end
        if (q4d.size() > 0) begin
            y4m = q4d[0]; ys4m = q4s[0];
        end
    end

    always @(posedge clk) begin
        logic acc;
        if (rst) begin
            q3d.delete(); q3s.delete(); y3m = 0; ys3m = 0; e3m = 0;
        end else if (f3) begin
            q3d.delete(); q3s.delete();
        end else begin
            acc = v3 && (q3d.size() < 2);
            if (q3d.size() > 0 && or3) begin
                void'(q3d.pop_front()); void'(q3s.pop_front());
            end
            if (acc) begin
                q3d.push_back(s3 < 3 ? 32'(d3 >> (32 * int'(s3))) : 32'd0);
                q3s.push_back(s3);
                if (s3 >= 3) e3m = ERR_EXP;
            end
        end
        if (q3d.size() > 0) begin
            y3m = q3d[0]; ys3m = q3s[0];
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("m4_out_valid", 32'(out_valid), 32'(q4d.size() != 0));
            chk("m4_in_ready", 32'(in_ready), 32'(q4d.size() < 2));
            chk("m4_y", y, y4m);
            chk("m4_y_sel", 32'(y_sel), 32'(ys4m));
            chk("m4_err", 32'(err), 32'd0);
            chk("m3_out_valid", 32'(out_valid3), 32'(q3d.size() != 0));
            chk("m3_in_ready", 32'(in_ready3), 32'(q3d.size() < 2));
            chk("m3_y", y3, y3m);
            chk("m3_y_sel", 32'(y_sel3), 32'(ys3m));
            chk("m3_err", 32'(err3), 32'(e3m));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        mon_en = 1;
        tick();
        rst = 0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_y", y, 0);
        chk("rst_y_sel", 32'(y_sel), 0);
        chk("rst_err", 32'(err3), 0);

        // Single word, sel=2
        in_valid = 1; sel = 2; out_ready = 1;
        tick();
        chk("one_valid", 32'(out_valid), 1);
        chk("one_y", y, 30);
        chk("one_y_sel", 32'(y_sel), 2);
        in_valid = 0;
        tick();
        chk("one_empty", 32'(out_valid), 0);
        chk("one_hold_y", y, 30);

        // Back-to-back stream
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; sel = 2'(i);
            tick();
            chk("stream_y", y, 32'(10 * (i + 1)));
            chk("stream_in_ready", 32'(in_ready), 1);
        end
        in_valid = 0;
        tick();

        // Stall absorption
        out_ready = 0; in_valid = 1; sel = 0;
        tick();
        sel = 3;
        tick();
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_y", y, 10);
        in_valid = 0; out_ready = 1;
        tick();
        chk("stall_pop_y", y, 40);
        chk("stall_pop_in_ready", 32'(in_ready), 1);
        tick();
        chk("stall_drained", 32'(out_valid), 0);

        // Flush while FULL, with a new input
        out_ready = 0; in_valid = 1; sel = 1;
        tick();
        sel = 2;
        tick();
        flush = 1; sel = 3;
        tick();
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        chk("flush_y_hold", y, 20);
        flush = 0; in_valid = 0; out_ready = 1;
        tick(); tick();

        // Out-of-range select on NSRC=3 instance
        v3 = 1; s3 = 3; or3 = 1;
        tick();
        chk("oor_y", y3, 0);
        chk("oor_y_sel", 32'(y_sel3), 3);
        chk("oor_err", 32'(err3), 32'(ERR_EXP));
        v3 = 0; f3 = 1;
        tick();
        chk("oor_err_after_flush", 32'(err3), 32'(ERR_EXP));
        f3 = 0; v3 = 1; s3 = 2;
        tick();
        chk("n3_y", y3, 30);
        v3 = 0;
        tick();

        // Mixed valid/ready pattern, checked by the model
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 3) != 1;
            sel = 2'(i % 4);
            out_ready = (i % 5) < 3;
            v3 = (i % 2) == 0;
            s3 = 2'(i % 3);
            or3 = (i % 4) != 3;
            tick();
        end
        in_valid = 0; v3 = 0; out_ready = 1; or3 = 1;
        tick(); tick(); tick();

        // Reset while FULL
        out_ready = 0; in_valid = 1; sel = 0;
        tick();
        sel = 1;
        tick();
        chk("prerst_full", 32'(in_ready), 0);
        in_valid = 0; rst = 1;
        tick();
        chk("rstfull_out_valid", 32'(out_valid), 0);
        chk("rstfull_y", y, 0);
        chk("rstfull_err", 32'(err3), 0);
        chk("rstfull_in_ready", 32'(in_ready), 1);
        rst = 0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
